// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-channel two-flop synchroniser, counter debouncer and
//               auto-repeat generator for raw push-button inputs. Emits a
//               clean level plus registered press/release/repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int              N             = 4,
  parameter int              CNT_W         = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE     = 20'hfffff,
  parameter int              REP_W         = 24,
  parameter logic [REP_W-1:0] REPEAT_DELAY = 24'd12_500_000,
  parameter logic [REP_W-1:0] REPEAT_PERIOD = 24'd2_500_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat
);

  localparam logic [CNT_W-1:0] DB_LAST  = DEBOUNCE - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REP_W-1:0] RD_LAST  = REPEAT_DELAY - REP_W'(1);
  localparam logic [REP_W-1:0] RP_LAST  = REPEAT_PERIOD - REP_W'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic             REP_EN   = (REPEAT_DELAY != '0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             s1_q, s2_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic [REP_W-1:0] rcnt_q, rcnt_d;
    rep_state_t       fsm_q, fsm_d;

    // Debounce: accept a new level only after DEBOUNCE consecutive differing samples
    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q != state_q) begin
        if (cnt_q == DB_LAST) begin
          state_d   = s2_q;
          press_d   = s2_q;
          release_d = ~s2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    // Auto-repeat: delay after press, then periodic pulses; release wins
    always_comb begin
      fsm_d    = fsm_q;
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          rcnt_d = '0;
          if (press_d && REP_EN) begin
            fsm_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (release_d) begin
            fsm_d  = ST_IDLE;
            rcnt_d = '0;
          end else if (rcnt_q == RD_LAST) begin
            fsm_d    = ST_REPEAT;
            rcnt_d   = '0;
            repeat_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + REP_ONE;
          end
        end
        ST_REPEAT: begin
          if (release_d) begin
            fsm_d  = ST_IDLE;
            rcnt_d = '0;
          end else if (rcnt_q == RP_LAST) begin
            rcnt_d   = '0;
            repeat_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + REP_ONE;
          end
        end
        default: begin
          fsm_d  = ST_IDLE;
          rcnt_d = '0;
        end
      endcase
    end

    // State registers: synchroniser, debouncer, pulse outputs and repeat FSM
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        state_q   <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        rcnt_q    <= '0;
        fsm_q     <= ST_IDLE;
      end else begin
        s1_q      <= btn_in[i];
        s2_q      <= s1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        rcnt_q    <= rcnt_d;
        fsm_q     <= fsm_d;
      end
    end

    assign btn_state[i]   = state_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench; two DUT builds (repeat on / repeat off)
//               compared every cycle against a behavioural model, plus
//               hand-computed literal expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RP = 3;
  localparam int RD [2] = '{10, 0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] st_a, pr_a, rl_a, rp_a;
  logic [N-1:0] st_b, pr_b, rl_b, rp_b;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;
  int  ed;

  always #5 clk = ~clk;

  button_conditioner #(
    .N(N), .CNT_W(20), .DEBOUNCE(20'd4), .REP_W(24),
    .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd3)
  ) u_dut_a (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_state(st_a), .btn_press(pr_a), .btn_release(rl_a), .btn_repeat(rp_a)
  );

  button_conditioner #(
    .N(N), .CNT_W(20), .DEBOUNCE(20'd4), .REP_W(24),
    .REPEAT_DELAY(24'd0), .REPEAT_PERIOD(24'd3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_state(st_b), .btn_press(pr_b), .btn_release(rl_b), .btn_repeat(rp_b)
  );

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level accepted when the last DB synchronised samples all differ from the
  // current level; repeats fall at press + RD + k*RP while held.
  bit      m_s1   [2][N];
  bit      m_s2   [2][N];
  bit      m_hist [2][N][DB];
  bit      m_st   [2][N];
  bit      m_pr   [2][N];
  bit      m_rl   [2][N];
  bit      m_rp   [2][N];
  bit      m_act  [2][N];
  longint  m_p    [2][N];
  longint  m_cyc = 0;

  always @(posedge clk) begin
    m_cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        bit     s2o, acc;
        longint dt;
        if (rst) begin
          m_s1[k][c] = 0; m_s2[k][c] = 0; m_st[k][c] = 0;
          m_pr[k][c] = 0; m_rl[k][c] = 0; m_rp[k][c] = 0; m_act[k][c] = 0;
          for (int d = 0; d < DB; d++) m_hist[k][c][d] = 0;
        end else begin
          s2o = m_s2[k][c];
          for (int d = DB - 1; d > 0; d--) m_hist[k][c][d] = m_hist[k][c][d-1];
          m_hist[k][c][0] = s2o;
          acc = 1;
          for (int d = 0; d < DB; d++) if (m_hist[k][c][d] == m_st[k][c]) acc = 0;
          m_pr[k][c] = acc && s2o;
          m_rl[k][c] = acc && !s2o;
          if (acc) m_st[k][c] = s2o;
          if (m_pr[k][c]) begin
            m_act[k][c] = (RD[k] != 0);
            m_p[k][c]   = m_cyc;
          end
          if (m_rl[k][c]) m_act[k][c] = 0;
          m_rp[k][c] = 0;
          if (m_act[k][c] && !m_pr[k][c]) begin
            dt = m_cyc - m_p[k][c];
            if (dt >= RD[k] && ((dt - RD[k]) % RP) == 0) m_rp[k][c] = 1;
          end
          m_s2[k][c] = m_s1[k][c];
          m_s1[k][c] = btn[c];
        end
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] e_st [2], e_pr [2], e_rl [2], e_rp [2];
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < N; c++) begin
          e_st[k][c] = m_st[k][c]; e_pr[k][c] = m_pr[k][c];
          e_rl[k][c] = m_rl[k][c]; e_rp[k][c] = m_rp[k][c];
        end
      chk("model_a_state",   st_a, e_st[0]);
      chk("model_a_press",   pr_a, e_pr[0]);
      chk("model_a_release", rl_a, e_rl[0]);
      chk("model_a_repeat",  rp_a, e_rp[0]);
      chk("model_b_state",   st_b, e_st[1]);
      chk("model_b_press",   pr_b, e_pr[1]);
      chk("model_b_release", rl_b, e_rl[1]);
      chk("model_b_repeat",  rp_b, e_rp[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    ed++;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rate;
    ed = 0;
    repeat (3) tick();
    chk("reset_state", st_a, 4'b0000);
    chk("reset_pulses", pr_a | rl_a | rp_a, 4'b0000);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Directed: edge numbering relative to first sampling of ch0 high
    btn[0] = 1'b1;
    ed = -1;
    while (ed < 105) begin
      tick();
      case (ed)
        4:  chk("ch0_state_before", st_a, 4'b0000);
        5:  begin
              chk("ch0_press",   pr_a, 4'b0001);
              chk("ch0_state",   st_a, 4'b0001);
              chk("ch0_press_b", pr_b, 4'b0001);
            end
        6:  chk("ch0_press_once", pr_a, 4'b0000);
        12: btn[0] = 1'b0;
        14: chk("ch0_no_early_rep", rp_a, 4'b0000);
        15: begin
              chk("ch0_first_rep", rp_a, 4'b0001);
              chk("ch0_rep_off_b", rp_b, 4'b0000);
            end
        18: begin
              chk("ch0_release", rl_a, 4'b0001);
              chk("ch0_rel_no_rep", rp_a, 4'b0000);
              chk("ch0_state_low", st_a, 4'b0000);
            end
        21: chk("ch0_no_rep_after", rp_a, 4'b0000);
        30: btn[1] = 1'b1;
        33: btn[1] = 1'b0;
        34: btn[1] = 1'b1;
        39: chk("ch1_bounce_none", pr_a, 4'b0000);
        40: chk("ch1_press", pr_a, 4'b0010);
        41: btn[1] = 1'b0;
        50: btn[3] = 1'b1;
        56: chk("ch3_press", pr_a, 4'b1000);
        66: chk("ch3_rep1", rp_a, 4'b1000);
        69: chk("ch3_rep2", rp_a, 4'b1000);
        70: rst = 1'b1;
        71: begin
              chk("rst_state",   st_a, 4'b0000);
              chk("rst_press",   pr_a, 4'b0000);
              chk("rst_release", rl_a, 4'b0000);
              chk("rst_repeat",  rp_a, 4'b0000);
              rst = 1'b0;
            end
        76: chk("ch3_repress_early", pr_a, 4'b0000);
        77: chk("ch3_repress", pr_a, 4'b1000);
        86: chk("ch3_rerep_early", rp_a, 4'b0000);
        87: chk("ch3_rerep", rp_a, 4'b1000);
        95: btn[3] = 1'b0;
        default: ;
      endcase
    end

    // Randomised phase: alternate bouncy and slow toggling, rare resets
    rate = 6;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i % 500 == 0) rate = (rate == 6) ? 30 : 6;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, rate - 1) == 0) btn[c] = ~btn[c];
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioner for the board push-buttons driving the paddles: synchronises N raw asynchronous button lines, debounces each independently, and emits a clean level plus single-cycle press, release and auto-repeat pulses. It sits at the board-input boundary, is reset by the reset generator's `rst` output, and feeds the paddle/game control logic. Channels are fully independent; no cross-channel interaction.

## Interface
Parameters:
- `N` = 4: number of button channels.
- `CNT_W` = 20: debounce counter width.
- `DEBOUNCE` = 20'hfffff: consecutive synchronised cycles a new level must hold before acceptance; must be ≥ 1.
- `REP_W` = 24: repeat counter width.
- `REPEAT_DELAY` = 24'd12_500_000: cycles from accepted press to first repeat pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD` = 24'd2_500_000: cycles between subsequent repeat pulses; must be ≥ 1.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in N: raw asynchronous button levels, active-high.
- `btn_state` out N: debounced level.
- `btn_press` out N: one-cycle pulse on accepted 0→1.
- `btn_release` out N: one-cycle pulse on accepted 1→0.
- `btn_repeat` out N: one-cycle auto-repeat pulse while held.

## Operation
- Synchroniser: two flops per channel, `s1 <= btn_in`, `s2 <= s1`. Only `s2` is used downstream.
- Debounce (per channel, `CNT_W`-bit counter `cnt`):
  - `s2 == btn_state`: `cnt <= 0`.
  - `s2 != btn_state` and `cnt == DEBOUNCE-1`: `btn_state <= s2`, `cnt <= 0`, and assert `btn_press` (if `s2`=1) or `btn_release` (if `s2`=0) for that cycle.
  - Otherwise: `cnt <= cnt + 1`.
  - Any single cycle of `s2 == btn_state` discards partial progress (glitch rejection).
- Auto-repeat FSM (per channel, `REP_W`-bit counter `rcnt`). States: IDLE, DELAY, REPEAT.
  - IDLE: on accepted press with `REPEAT_DELAY` ≠ 0, go to DELAY with `rcnt <= 0`. If `REPEAT_DELAY` = 0, stay in IDLE.
  - DELAY: if `rcnt == REPEAT_DELAY-1`, pulse `btn_repeat`, set `rcnt <= 0`, and go to REPEAT. Otherwise increment `rcnt`.
  - REPEAT: if `rcnt == REPEAT_PERIOD-1`, pulse `btn_repeat` and set `rcnt <= 0`. Otherwise increment `rcnt`.
  - Accepted release in DELAY or REPEAT: go to IDLE with `rcnt <= 0`. Release has priority; no repeat pulse on the release cycle.
  - The press pulse is never also a repeat pulse.
- Pulse outputs are registered. Each pulse is high for exactly one cycle per event.
- `btn_press` and `btn_release` are mutually exclusive per channel. `btn_repeat` never coincides with `btn_press` or `btn_release` on the same channel.

## Timing
- Reset (`rst`=1 at an edge): all sync flops, counters, `btn_state`, `btn_press`, `btn_release` and `btn_repeat` go to 0; FSM goes to IDLE. Reset overrides all other activity in that cycle.
- Edge numbering: edge 0 is the first rising edge at which `btn_in` is sampled at its new level, held stable afterwards.
  - `s2` reflects the new level after edge 1.
  - `btn_state` and the press/release pulse update at edge `DEBOUNCE`+1.
  - The pulse deasserts at edge `DEBOUNCE`+2.
- Repeat timing, taking the press edge as P:
  - First `btn_repeat` at edge P+`REPEAT_DELAY`.
  - Subsequent pulses at P+`REPEAT_DELAY`+k·`REPEAT_PERIOD`, for k ≥ 1.
- Reset mid-operation: in-flight debounce and repeat progress is lost. A button held through reset is re-acquired as a fresh press, occurring `DEBOUNCE`+1 edges after the first post-reset sampling edge.
- Counter widths must hold `DEBOUNCE-1` and `max(REPEAT_DELAY, REPEAT_PERIOD)-1`. Counters never wrap in normal operation.

## Test plan
Unless noted, all scenarios use `DEBOUNCE`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `N`=4.
- Clean press on ch0, sampled at edge 0 and held → `btn_state[0]`=1 and `btn_press[0]`=1 at edge 5 only; other channels and other pulses stay 0.
- Bounce: ch1 high for 3 cycles, low for 1, then high steady → no acceptance during the bounce; `btn_press[1]` fires exactly once, 5 edges after the final rising sample.
- Hold ch2 for 30 cycles after press at edge P → `btn_repeat[2]` at P+10, P+13, P+16, … and never at P. Release → one `btn_release[2]` and no further repeats.
- Release on the same cycle a repeat would fire (release accepted at P+13) → `btn_release`=1, `btn_repeat`=0, FSM returns to IDLE.
- Assert `rst` for 1 cycle while ch3 is held and repeating → all outputs 0 on the next edge; new `btn_press[3]` 5 edges after the first post-reset sample, repeat timing restarts from that press.
- `REPEAT_DELAY`=0 build, long hold → `btn_repeat` stays 0 throughout; press and release still correct.
